vec_wb_mailbox: RTL and testbench

- Parametrised Wishbone-slave mailbox between the Caravel management SoC and the vector coprocessor lanes.
- Provides NUM_CH independent channels. Each channel has one command FIFO (SoC to coprocessor) and one response FIFO (coprocessor to SoC).
- Each channel also carries status, flush and interrupt control.
- Sits between the user_project_wrapper Wishbone port and the coprocessor valid/ready stream interfaces.

---
 rtl/vec_mbox_pkg.sv | 51 +++++
 rtl/vec_wb_mailbox_if.sv | 23 ++
 rtl/vec_mbox_fifo.sv | 55 +++++
 rtl/vec_wb_mailbox.sv | 182 ++++++++++++++++++
 tb/tb_vec_wb_mailbox.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/vec_mbox_pkg.sv
// Shared constants and types for the vector coprocessor Wishbone mailbox.
// Register offsets, STATUS/CTRL bit positions and the per-channel status record.
package vec_mbox_pkg;

   localparam logic [3:0] OFS_CMD  = 4'h0;
   localparam logic [3:0] OFS_RSP  = 4'h4;
   localparam logic [3:0] OFS_STAT = 4'h8;
   localparam logic [3:0] OFS_CTRL = 4'hC;

   localparam int STAT_CMD_CNT_LSB = 0;
   localparam int STAT_RSP_CNT_LSB = 8;
   localparam int STAT_CMD_FULL    = 16;
   localparam int STAT_RSP_EMPTY   = 17;
   localparam int STAT_OVF         = 18;
   localparam int STAT_UNF         = 19;
   localparam int STAT_IRQ_EN      = 20;

   localparam int CTRL_FLUSH_CMD = 0;
   localparam int CTRL_FLUSH_RSP = 1;
   localparam int CTRL_CLR_ERR   = 2;
   localparam int CTRL_IRQ_EN    = 3;

   typedef struct packed {
      logic [7:0] cmd_count;
      logic [7:0] rsp_count;
      logic       cmd_full;
      logic       rsp_empty;
      logic       ovf;
      logic       unf;
      logic       irq_en;
   } ch_status_t;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_ACK  = 1'b1
   } wb_state_e;

   function automatic logic [31:0] pack_status(input ch_status_t s);
      logic [31:0] w;
      w = '0;
      w[STAT_CMD_CNT_LSB +: 8] = s.cmd_count;
      w[STAT_RSP_CNT_LSB +: 8] = s.rsp_count;
      w[STAT_CMD_FULL]         = s.cmd_full;
      w[STAT_RSP_EMPTY]        = s.rsp_empty;
      w[STAT_OVF]              = s.ovf;
      w[STAT_UNF]              = s.unf;
      w[STAT_IRQ_EN]           = s.irq_en;
      return w;
   endfunction

endpackage

// File: rtl/vec_wb_mailbox_if.sv
// Wishbone slave bus bundle between the management SoC and the mailbox.
interface vec_wb_mailbox_if;

   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/vec_mbox_fifo.sv
// Synchronous FIFO with flush, used for every command and response queue.
// Push when full and pop when empty are ignored; flush beats push and pop.
module vec_mbox_fifo #(
   parameter int  DATA_W = 32,
   parameter int  DEPTH  = 4,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);

   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !do_push)
            count <= count - CW'(1);
      end
   end

   // Storage is not reset; contents behind an empty count are never observed.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vec_wb_mailbox.sv
// Wishbone mailbox: NUM_CH channels, each with a command and a response FIFO,
// sticky overflow/underflow flags and a level interrupt on pending responses.
//
// state   | meaning
// WB_IDLE | waiting for stb&cyc to an in-window address; accepts on this edge
// WB_ACK  | ack and read data driven for exactly one cycle, no new accept
module vec_wb_mailbox
   import vec_mbox_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          NUM_CH    = 2,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   vec_wb_mailbox_if.slave          wb,
   output logic [NUM_CH-1:0]        cmd_val,
   input  logic [NUM_CH-1:0]        cmd_rdy,
   output logic [NUM_CH*DATA_W-1:0] cmd_msg,
   input  logic [NUM_CH-1:0]        rsp_val,
   output logic [NUM_CH-1:0]        rsp_rdy,
   input  logic [NUM_CH*DATA_W-1:0] rsp_msg,
   output logic [NUM_CH-1:0]        irq
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [31:0] WIN_BYTES = 32'(NUM_CH * 16);

   wb_state_e   state_q;
   wb_state_e   state_d;
   logic        accept;
   logic [31:0] ofs;
   logic [3:0]  reg_ofs;
   logic        in_window;
   logic [31:0] rd_data;
   logic [31:0] dat_q;
   logic        unused_sel;

   logic [NUM_CH-1:0] ch_hit;
   logic [NUM_CH-1:0] cmd_push;
   logic [NUM_CH-1:0] cmd_pop;
   logic [NUM_CH-1:0] rsp_push;
   logic [NUM_CH-1:0] rsp_pop;
   logic [NUM_CH-1:0] ctrl_wr;
   logic [NUM_CH-1:0] cmd_full;
   logic [NUM_CH-1:0] cmd_empty;
   logic [NUM_CH-1:0] rsp_full;
   logic [NUM_CH-1:0] rsp_empty;
   logic [NUM_CH-1:0] ovf_q;
   logic [NUM_CH-1:0] unf_q;
   logic [NUM_CH-1:0] irq_en_q;

   logic [AW:0]                   cmd_count [NUM_CH];
   logic [AW:0]                   rsp_count [NUM_CH];
   logic [NUM_CH-1:0][DATA_W-1:0] cmd_head;
   logic [NUM_CH-1:0][DATA_W-1:0] rsp_head;
   ch_status_t                    ch_stat   [NUM_CH];

   // Byte lanes are ignored: every access is treated as a full word.
   assign unused_sel = ^wb.wbs_sel_i;

   assign ofs       = wb.wbs_adr_i - BASE_ADDR;
   assign reg_ofs   = ofs[3:0];
   assign in_window = (wb.wbs_adr_i >= BASE_ADDR) && (ofs < WIN_BYTES);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WB_IDLE;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         dat_q   <= accept ? rd_data : '0;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         WB_IDLE: begin
            accept = wb.wbs_stb_i & wb.wbs_cyc_i & in_window;
            if (accept) state_d = WB_ACK;
         end
         WB_ACK:  state_d = WB_IDLE;
         default: state_d = WB_IDLE;
      endcase
   end

   assign wb.wbs_ack_o = (state_q == WB_ACK);
   assign wb.wbs_dat_o = dat_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic ovf_r;
      logic unf_r;
      logic irq_en_r;

      assign ch_hit[c]   = in_window && (ofs[31:4] == 28'(c));
      assign cmd_push[c] = accept & ch_hit[c] & wb.wbs_we_i & (reg_ofs == OFS_CMD);
      assign rsp_pop[c]  = accept & ch_hit[c] & ~wb.wbs_we_i & (reg_ofs == OFS_RSP);
      assign ctrl_wr[c]  = accept & ch_hit[c] & wb.wbs_we_i & (reg_ofs == OFS_CTRL);
      assign cmd_pop[c]  = cmd_val[c] & cmd_rdy[c];
      assign rsp_push[c] = rsp_val[c] & rsp_rdy[c];

      vec_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_cmd_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (cmd_push[c]),
         .pop   (cmd_pop[c]),
         .flush (ctrl_wr[c] & wb.wbs_dat_i[CTRL_FLUSH_CMD]),
         .din   (DATA_W'(wb.wbs_dat_i)),
         .head  (cmd_head[c]),
         .full  (cmd_full[c]),
         .empty (cmd_empty[c]),
         .count (cmd_count[c])
      );

      vec_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rsp_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (rsp_push[c]),
         .pop   (rsp_pop[c]),
         .flush (ctrl_wr[c] & wb.wbs_dat_i[CTRL_FLUSH_RSP]),
         .din   (rsp_msg[c*DATA_W +: DATA_W]),
         .head  (rsp_head[c]),
         .full  (rsp_full[c]),
         .empty (rsp_empty[c]),
         .count (rsp_count[c])
      );

      // Flags see pre-edge fullness, so a same-edge coprocessor pop cannot save a write.
      always_ff @(posedge clk) begin
         if (reset) begin
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            irq_en_r <= 1'b0;
         end else begin
            if (ctrl_wr[c]) begin
               irq_en_r <= wb.wbs_dat_i[CTRL_IRQ_EN];
               if (wb.wbs_dat_i[CTRL_CLR_ERR]) begin
                  ovf_r <= 1'b0;
                  unf_r <= 1'b0;
               end
            end
            if (cmd_push[c] && cmd_full[c]) ovf_r <= 1'b1;
            if (rsp_pop[c] && rsp_empty[c]) unf_r <= 1'b1;
         end
      end

      assign ovf_q[c]    = ovf_r;
      assign unf_q[c]    = unf_r;
      assign irq_en_q[c] = irq_en_r;

      assign ch_stat[c].cmd_count = 8'(cmd_count[c]);
      assign ch_stat[c].rsp_count = 8'(rsp_count[c]);
      assign ch_stat[c].cmd_full  = cmd_full[c];
      assign ch_stat[c].rsp_empty = rsp_empty[c];
      assign ch_stat[c].ovf       = ovf_r;
      assign ch_stat[c].unf       = unf_r;
      assign ch_stat[c].irq_en    = irq_en_r;
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_hit[i] && !wb.wbs_we_i) begin
            case (reg_ofs)
               OFS_RSP:  rd_data = rsp_empty[i] ? '0 : 32'(rsp_head[i]);
               OFS_STAT: rd_data = pack_status(ch_stat[i]);
               OFS_CTRL: rd_data = {31'b0, irq_en_q[i]};
               default:  rd_data = '0;
            endcase
         end
      end
   end

   assign cmd_val = ~cmd_empty;
   assign cmd_msg = cmd_head;
   assign rsp_rdy = ~rsp_full;
   assign irq     = irq_en_q & ~rsp_empty;

endmodule

// File: tb/tb_vec_wb_mailbox.sv
// Bench for vec_wb_mailbox: Wishbone reads scoreboarded through a queue of
// expected data, coprocessor-side outputs checked against a command model.
module tb_vec_wb_mailbox;

   localparam int          NUM_CH = 2;
   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] BASE   = 32'h3000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [NUM_CH-1:0]        cmd_val;
   logic [NUM_CH-1:0]        cmd_rdy = '0;
   logic [NUM_CH*DATA_W-1:0] cmd_msg;
   logic [NUM_CH-1:0]        rsp_val = '0;
   logic [NUM_CH-1:0]        rsp_rdy;
   logic [NUM_CH*DATA_W-1:0] rsp_msg = '0;
   logic [NUM_CH-1:0]        irq;

   vec_wb_mailbox_if wb();

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];
   logic [31:0] exp_cmd0[$];

   always #5 clk = ~clk;

   vec_wb_mailbox #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk     (clk),
      .reset   (reset),
      .wb      (wb),
      .cmd_val (cmd_val),
      .cmd_rdy (cmd_rdy),
      .cmd_msg (cmd_msg),
      .rsp_val (rsp_val),
      .rsp_rdy (rsp_rdy),
      .rsp_msg (rsp_msg),
      .irq     (irq)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      @(negedge clk);
      wb.wbs_stb_i = 1'b1;
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_we_i  = we;
      wb.wbs_adr_i = adr;
      wb.wbs_dat_i = dat;
   endtask

   task automatic wb_finish(output logic acked, output logic [31:0] rdata);
      acked = 1'b0;
      rdata = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (wb.wbs_ack_o) begin
            acked = 1'b1;
            rdata = wb.wbs_dat_o;
            break;
         end
      end
      wb.wbs_stb_i = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input string tag);
      logic a;
      logic [31:0] d;
      wb_start(1'b1, adr, dat);
      wb_finish(a, d);
      chk({tag, "_ack"}, 64'(a), 64'(1));
   endtask

   task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
      logic a;
      logic [31:0] d;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      wb_start(1'b0, adr, 32'h0);
      wb_finish(a, d);
      chk({tag, "_ack"}, 64'(a), 64'(1));
      chk(tag_q.pop_front(), 64'(d), 64'(exp_q.pop_front()));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a;
      logic [31:0] d;
      logic any_ack;

      wb.wbs_stb_i = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_sel_i = 4'hF;
      wb.wbs_adr_i = '0;
      wb.wbs_dat_i = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk("rst_cmd_val", 64'(cmd_val), 64'(0));
      chk("rst_rsp_rdy", 64'(rsp_rdy), 64'(2'b11));
      chk("rst_irq", 64'(irq), 64'(0));
      chk("rst_ack", 64'(wb.wbs_ack_o), 64'(0));
      wb_read(BASE + 32'h8, 32'h0002_0000, "rst_stat0");

      // Single command on channel 1 appears on the coprocessor side.
      wb_write(BASE + 32'h10, 32'hDEAD_BEEF, "cmd1_wr");
      chk("cmd1_val", 64'(cmd_val[1]), 64'(1));
      chk("cmd1_msg", 64'(cmd_msg[63:32]), 64'(32'hDEAD_BEEF));
      wb_read(BASE + 32'h18, 32'h0002_0001, "stat1_cnt");

      // Overfill channel 0: fifth write is dropped and flags ovf.
      for (int i = 0; i < 5; i++) begin
         wb_write(BASE, 32'hA0 + 32'(i), "cmd0_fill");
         if (i < DEPTH) exp_cmd0.push_back(32'hA0 + 32'(i));
      end
      wb_read(BASE + 32'h8, 32'h0007_0004, "stat0_ovf");
      wb_write(BASE + 32'hC, 32'h4, "ctrl_clr");
      wb_read(BASE + 32'h8, 32'h0003_0004, "stat0_clr");

      // Responses, interrupt and underflow.
      wb_write(BASE + 32'hC, 32'h8, "ctrl_irqen");
      wb_read(BASE + 32'hC, 32'h1, "ctrl_rd");
      @(negedge clk);
      rsp_val[0] = 1'b1;
      rsp_msg[31:0] = 32'h11;
      @(negedge clk);
      rsp_msg[31:0] = 32'h22;
      @(negedge clk);
      rsp_val[0] = 1'b0;
      chk("irq_set", 64'(irq[0]), 64'(1));
      wb_read(BASE + 32'h4, 32'h11, "rsp_first");
      wb_read(BASE + 32'h4, 32'h22, "rsp_second");
      chk("irq_clr", 64'(irq[0]), 64'(0));
      wb_read(BASE + 32'h4, 32'h0, "rsp_unf_data");
      wb_read(BASE + 32'h8, 32'h001B_0004, "stat0_unf");

      // Write to a full FIFO on the same edge as a coprocessor pop.
      chk("head_before", 64'(cmd_msg[31:0]), 64'(exp_cmd0[0]));
      wb_start(1'b1, BASE, 32'hBB);
      cmd_rdy[0] = 1'b1;
      wb_finish(a, d);
      cmd_rdy[0] = 1'b0;
      chk("race_ack", 64'(a), 64'(1));
      void'(exp_cmd0.pop_front());
      chk("head_after", 64'(cmd_msg[31:0]), 64'(exp_cmd0[0]));
      wb_read(BASE + 32'h8, 32'h001E_0003, "stat0_race");

      // Refill across the pointer wrap, then drain in order.
      wb_write(BASE + 32'hC, 32'hC, "ctrl_clr2");
      wb_write(BASE, 32'hA5, "cmd0_wrap");
      exp_cmd0.push_back(32'hA5);
      @(negedge clk);
      cmd_rdy[0] = 1'b1;
      for (int i = 0; i < 10 && exp_cmd0.size() > 0; i++) begin
         if (cmd_val[0]) chk("cmd_order", 64'(cmd_msg[31:0]), 64'(exp_cmd0.pop_front()));
         @(negedge clk);
      end
      cmd_rdy[0] = 1'b0;
      chk("cmd_drain_left", 64'(exp_cmd0.size()), 64'(0));
      chk("cmd0_empty", 64'(cmd_val[0]), 64'(0));

      // Reset during a pending read cancels the ack.
      @(negedge clk);
      wb.wbs_stb_i = 1'b1;
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_adr_i = BASE + 32'h8;
      reset = 1'b1;
      any_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         any_ack |= wb.wbs_ack_o;
      end
      wb.wbs_stb_i = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      any_ack |= wb.wbs_ack_o;
      chk("rst_mid_noack", 64'(any_ack), 64'(0));
      chk("rst_mid_cmdval", 64'(cmd_val), 64'(0));
      wb_read(BASE + 32'h18, 32'h0002_0000, "rst_mid_stat1");

      // Flush beats a concurrent coprocessor response push.
      @(negedge clk);
      rsp_val[0] = 1'b1;
      rsp_msg[31:0] = 32'h33;
      @(negedge clk);
      rsp_val[0] = 1'b0;
      chk("irq_masked", 64'(irq[0]), 64'(0));
      wb_read(BASE + 32'h8, 32'h0000_0100, "stat0_rsp1");
      wb_start(1'b1, BASE + 32'hC, 32'h3);
      rsp_val[0] = 1'b1;
      rsp_msg[31:0] = 32'h44;
      wb_finish(a, d);
      rsp_val[0] = 1'b0;
      chk("flush_ack", 64'(a), 64'(1));
      wb_read(BASE + 32'h8, 32'h0002_0000, "stat0_flush");

      // Wrong direction and out-of-window accesses.
      wb_read(BASE, 32'h0, "cmd_rd_zero");
      wb_write(BASE + 32'h8, 32'hFFFF_FFFF, "stat_wr");
      wb_write(BASE + 32'h4, 32'h1234_5678, "rsp_wr");
      wb_read(BASE + 32'h8, 32'h0002_0000, "stat0_nowr");
      wb_start(1'b1, BASE + 32'h20, 32'hCC);
      wb_finish(a, d);
      chk("oow_hi_noack", 64'(a), 64'(0));
      wb_start(1'b0, BASE - 32'h4, 32'h0);
      wb_finish(a, d);
      chk("oow_lo_noack", 64'(a), 64'(0));
      wb_read(BASE + 32'h18, 32'h0002_0000, "stat1_oow");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
